// File: rtl/stopwatch_ctrl.sv
// Stopwatch button controller: synchronizes and debounces the start/stop and
// lap/clear buttons, turns debounced rising edges into presses, and sequences
// the IDLE/RUN/STOP/LAP states that gate the counter and freeze the display.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       tick,
  output logic       count_en,
  output logic       clr,
  output logic       freeze,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_e;

  // Button index 0 is start/stop, index 1 is lap/clear.
  localparam int                NB       = 2;
  localparam logic [DEB_W-1:0]  CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [NB-1:0]             btn_raw;
  logic [NB-1:0]             sync1_q, sync2_q;
  logic [NB-1:0]             deb_q, deb_dly_q;
  logic [NB-1:0][DEB_W-1:0]  cnt_q;
  logic [NB-1:0]             press;

  state_e state_q;
  logic   clr_q, freeze_q;

  assign btn_raw = {btn_lap, btn_ss};

  // Two-flop synchronizers for the asynchronous button inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing
  // samples; any sample matching the accepted level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
    end else begin
      deb_dly_q <= deb_q;
      for (int b = 0; b < NB; b++) begin
        if (sync2_q[b] != deb_q[b]) begin
          if (cnt_q[b] == CNT_LAST) begin
            deb_q[b] <= sync2_q[b];
            cnt_q[b] <= '0;
          end else begin
            cnt_q[b] <= cnt_q[b] + 1'b1;
          end
        end else begin
          cnt_q[b] <= '0;
        end
      end
    end
  end

  // A press is the debounced rising edge; releases are ignored.
  assign press = deb_q & ~deb_dly_q;

  // Control FSM with registered freeze and one-cycle clear; start/stop has
  // priority, so a lap press on the same edge is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      clr_q    <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press[0]) begin
            state_q  <= RUN;
            freeze_q <= 1'b0;
          end
        end
        RUN: begin
          if (press[0]) begin
            state_q  <= STOP;
            freeze_q <= 1'b0;
          end else if (press[1]) begin
            state_q  <= LAP;
            freeze_q <= 1'b1;
          end
        end
        LAP: begin
          if (press[0]) begin
            state_q  <= STOP;
            freeze_q <= 1'b0;
          end else if (press[1]) begin
            state_q  <= RUN;
            freeze_q <= 1'b0;
          end
        end
        STOP: begin
          if (press[0]) begin
            state_q  <= RUN;
            freeze_q <= 1'b0;
          end else if (press[1]) begin
            state_q  <= IDLE;
            freeze_q <= 1'b0;
            clr_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          freeze_q <= 1'b0;
        end
      endcase
    end
  end

  // The counter advances only on ticks while running or lap-holding.
  assign count_en = tick & ((state_q == RUN) || (state_q == LAP));
  assign clr      = clr_q;
  assign freeze   = freeze_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEB_CYCLES=4: directed vector table, corner
// sequences, and random button activity against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_LAP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0, btn_lap = 1'b0, tick = 1'b0;
  logic       count_en, clr, freeze;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .DEB_W(3)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .tick(tick), .count_en(count_en), .clr(clr), .freeze(freeze),
    .state(state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Next state on a start/stop press and on a lap press, indexed by state.
  int ss_next [4] = '{S_RUN, S_STOP, S_RUN, S_STOP};
  int lap_next[4] = '{S_IDLE, S_LAP, S_IDLE, S_RUN};

  int m_state;
  bit m_clr;
  bit m_deb [2];
  bit m_pend[2];
  bit syq  [2][$];   // two-stage synchronizer as a 2-deep FIFO
  bit hist [2][$];   // recent synchronized samples seen by the debouncer

  task automatic model_reset();
    m_state = S_IDLE;
    m_clr   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_deb[b]  = 1'b0;
      m_pend[b] = 1'b0;
      syq[b].delete();
      syq[b].push_back(1'b0);
      syq[b].push_back(1'b0);
      hist[b].delete();
    end
  endtask

  // One clock edge of the model. A level is accepted once the last DEB
  // synchronized samples all disagree with the accepted level; a press is
  // acted on at the edge after the accepted level rises.
  task automatic model_step(input bit r_ss, input bit r_lap);
    bit raw[2];
    bit p[2];
    bit s_now, all_diff;
    int prev;
    raw[0] = r_ss;
    raw[1] = r_lap;
    for (int b = 0; b < 2; b++) begin
      p[b] = m_pend[b];
      m_pend[b] = 1'b0;
      s_now = syq[b].pop_front();
      syq[b].push_back(raw[b]);
      hist[b].push_back(s_now);
      while (hist[b].size() > DEB) void'(hist[b].pop_front());
      if (hist[b].size() == DEB) begin
        all_diff = 1'b1;
        for (int k = 0; k < hist[b].size(); k++)
          if (hist[b][k] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_deb[b]  = ~m_deb[b];
          m_pend[b] = m_deb[b];
          hist[b].delete();
        end
      end
    end
    prev = m_state;
    if (p[0])      m_state = ss_next[m_state];
    else if (p[1]) m_state = lap_next[m_state];
    m_clr = (prev == S_STOP) && (m_state == S_IDLE);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a negedge: drive inputs, check the combinational
  // enable against the pre-edge state, advance one edge, check registers.
  task automatic cycle(input bit ss, input bit lap, input bit tk);
    btn_ss  = ss;
    btn_lap = lap;
    tick    = tk;
    #1;
    chk("count_en", int'(count_en), int'(tk && (m_state == S_RUN || m_state == S_LAP)));
    @(posedge clk);
    model_step(ss, lap);
    @(negedge clk);
    chk("state",  int'(state),  m_state);
    chk("freeze", int'(freeze), int'(m_state == S_LAP));
    chk("clr",    int'(clr),    int'(m_clr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_ss = 1'b0; btn_lap = 1'b0; tick = 1'b1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_state",    int'(state),    0);
    chk("rst_clr",      int'(clr),      0);
    chk("rst_freeze",   int'(freeze),   0);
    chk("rst_count_en", int'(count_en), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Hold a button combination 10 cycles, then release for 10 cycles.
  task automatic press(input bit ss, input bit lap);
    repeat (10) cycle(ss, lap, ($urandom_range(0, 2) == 0));
    repeat (10) cycle(1'b0, 1'b0, ($urandom_range(0, 2) == 0));
  endtask

  typedef struct {
    bit       ss, lap, tk;
    int       n;
    int       st;
    bit       cen, frz;
  } vec_t;

  vec_t vecs[17];
  int   nclr;

  initial begin
    // {ss, lap, tick, cycles, state after, count_en with tick, freeze}
    vecs = '{
      '{0, 0, 1, 10, S_IDLE, 0, 0},
      '{0, 1, 1, 10, S_IDLE, 0, 0},
      '{0, 0, 1, 10, S_IDLE, 0, 0},
      '{1, 0, 1, 10, S_RUN,  1, 0},
      '{0, 0, 1, 10, S_RUN,  1, 0},
      '{0, 1, 1, 10, S_LAP,  1, 1},
      '{0, 0, 1, 10, S_LAP,  1, 1},
      '{0, 1, 1, 10, S_RUN,  1, 0},
      '{0, 0, 1, 10, S_RUN,  1, 0},
      '{1, 0, 1, 10, S_STOP, 0, 0},
      '{0, 0, 1, 10, S_STOP, 0, 0},
      '{1, 0, 1, 10, S_RUN,  1, 0},
      '{0, 0, 1, 10, S_RUN,  1, 0},
      '{1, 0, 1, 10, S_STOP, 0, 0},
      '{0, 0, 1, 10, S_STOP, 0, 0},
      '{0, 1, 1, 10, S_IDLE, 0, 0},
      '{0, 0, 1, 10, S_IDLE, 0, 0}
    };

    model_reset();
    do_reset();

    // Latency: button high before edge 1 moves the state at edge 7.
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, (i % 3 == 0));
      if (i == 6) chk("lat_edge6", int'(state), S_IDLE);
      if (i == 7) chk("lat_edge7", int'(state), S_RUN);
    end
    chk("lat_hold", int'(state), S_RUN);

    // Directed vector table.
    do_reset();
    foreach (vecs[v]) begin
      for (int c = 0; c < vecs[v].n; c++) cycle(vecs[v].ss, vecs[v].lap, vecs[v].tk);
      chk("vec_state",    int'(state),    vecs[v].st);
      chk("vec_count_en", int'(count_en), int'(vecs[v].cen));
      chk("vec_freeze",   int'(freeze),   int'(vecs[v].frz));
    end

    // Bounce 1,1,0,1,1,1,1,1 then held: state changes at edge 10 only.
    do_reset();
    begin
      bit pat[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
      for (int i = 1; i <= 30; i++) begin
        cycle((i <= 8) ? pat[i-1] : 1'b1, 1'b0, 1'b0);
        if (i == 9)  chk("bounce_e9",  int'(state), S_IDLE);
        if (i == 10) chk("bounce_e10", int'(state), S_RUN);
      end
      chk("bounce_once", int'(state), S_RUN);
    end
    repeat (10) cycle(1'b0, 1'b0, 1'b0);

    // STOP then lap: exactly one clear pulse.
    press(1'b1, 1'b0);
    chk("to_stop", int'(state), S_STOP);
    nclr = 0;
    for (int i = 0; i < 20; i++) begin
      cycle((i < 10) ? 1'b0 : 1'b0, (i < 10), 1'b1);
      if (clr) nclr++;
    end
    chk("clr_pulses", nclr, 1);
    chk("clr_idle", int'(state), S_IDLE);

    // Simultaneous presses in RUN: start/stop wins, lap not queued.
    press(1'b1, 1'b0);
    chk("sim_run", int'(state), S_RUN);
    press(1'b1, 1'b1);
    chk("sim_stop", int'(state), S_STOP);
    repeat (10) cycle(1'b0, 1'b0, 1'b1);
    chk("sim_noqueue", int'(state), S_STOP);

    // Reset mid-debounce with a press pending, from LAP.
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("pre_rst_lap", int'(state), S_LAP);
    repeat (6) cycle(1'b1, 1'b0, 1'b1);
    tick = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_state",    int'(state),    0);
    chk("async_freeze",   int'(freeze),   0);
    chk("async_clr",      int'(clr),      0);
    chk("async_count_en", int'(count_en), 0);
    btn_ss = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (15) cycle(1'b0, 1'b0, 1'b1);
    chk("no_press_after_rst", int'(state), S_IDLE);

    // Random button activity against the model.
    for (int seg = 0; seg < 150; seg++) begin
      bit rs, rl;
      int len;
      rs  = ($urandom_range(0, 2) == 0);
      rl  = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 60) == 0) do_reset();
      for (int c = 0; c < len; c++) cycle(rs, rl, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
